pcler8_ctrl: RTL and testbench
==============================

PCLER8_CTRL -- requirements
Module: pcler8_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: counter width in bits.
REQ-002 SHALL have parameter RELOAD_RST, default 0: reset value of the reload register.
REQ-003 SHALL have parameter ONE_SHOT, default 0: when 1, the counter stops after the first wrap.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port load, input, 1 bit: parallel load of load_data into the count.
REQ-007 SHALL have port clr, input, 1 bit: synchronous clear of the count.
REQ-008 SHALL have port cnt_en, input, 1 bit: count-up enable.
REQ-009 SHALL have port load_data, input, WIDTH bits: parallel load value.
REQ-010 SHALL have port reload_we, input, 1 bit: write strobe for the reload register.
REQ-011 SHALL have port reload_data, input, WIDTH bits: value written to the reload register.
REQ-012 SHALL have port count, output, WIDTH bits: registered counter value.
REQ-013 SHALL have port tc, output, 1 bit: registered terminal-count pulse, one cycle per wrap.
REQ-014 SHALL have port running, output, 1 bit: high while the FSM is in RUN.
REQ-015 SHALL have port irq, output, 1 bit: sticky wrap flag (see Configuration).
REQ-016 SHALL have port irq_clr, input, 1 bit: clears irq.

Function
REQ-017 Per-cycle priority SHALL be: load > clr > count > hold.
REQ-018 On load, count SHALL be load_data on the next edge, and the FSM SHALL go to IDLE.
REQ-019 On clr without load, count SHALL become 0 on the next edge, and the FSM SHALL go to IDLE.
REQ-020 With cnt_en=1, no load and no clr, and FSM not in DONE, the FSM SHALL enter or stay in RUN and count SHALL increment by 1.
REQ-021 In the same case with count equal to all-ones, count SHALL take the reload register value instead of wrapping to 0, and tc SHALL be 1 on the following cycle only.
REQ-022 With cnt_en=0 and no load and no clr, count SHALL hold and the FSM SHALL go RUN->IDLE.
REQ-023 FSM states SHALL be IDLE, RUN and DONE.
REQ-024 With ONE_SHOT=1, a wrap SHALL move the FSM to DONE; in DONE, cnt_en is ignored and count holds; only load or clr exit DONE, to IDLE.
REQ-025 With ONE_SHOT=0, DONE SHALL be unreachable.
REQ-026 reload_we SHALL update the reload register on the next edge; a wrap in that same cycle SHALL use the old reload value.
REQ-027 tc SHALL be 0 in every cycle except the one following a wrap; load or clr in the wrap cycle preempts the wrap, so no tc.

Reset
REQ-028 While rst_n=0, the block SHALL hold count=0, reload=RELOAD_RST, tc=0, irq=0, FSM=IDLE, running=0, applied asynchronously.
REQ-029 Reset assertion mid-count SHALL abort immediately; after release, counting SHALL resume only on cnt_en.

Configuration
REQ-030 With macro PCLER8_CTRL_IRQ_EN defined, irq SHALL set on every tc and clear on irq_clr; a simultaneous set and clear SHALL leave irq set.
REQ-031 Without PCLER8_CTRL_IRQ_EN, irq SHALL be tied to 0 and irq_clr SHALL be ignored; no irq flop is present.

Structure
REQ-032 A shared package pcler8_pkg SHALL hold the FSM state enum (IDLE/RUN/DONE) and the default width constant.
REQ-033 Next-count combinational logic (priority mux, increment, all-ones detect, reload select) SHALL live in sub-module cnt8_next; registers and FSM SHALL live in pcler8_ctrl.

Verification
REQ-034 Reset, then load_data=8'hFD with load=1, then cnt_en=1 for 4 cycles, reload=8'h10 -> count shows FE, FF, 10, 11; tc high exactly once, in the cycle count=10.
REQ-035 cnt_en=1 with load=1 and clr=1 in the same cycle, load_data=8'h5A -> count=5A and running=0.
REQ-036 ONE_SHOT=1, count=FF, cnt_en=1 held -> count=reload value, FSM=DONE, count frozen for 5 cycles; then clr=1 -> count=00, FSM=IDLE.
REQ-037 reload_we=1 with reload_data=8'h33 in the wrap cycle, old reload=8'h10 -> count=10; the next wrap gives count=33.
REQ-038 rst_n pulled low asynchronously mid-count at count=8'h42 -> count=00, tc=0 and irq=0 immediately, without waiting for a clock edge.
REQ-039 With PCLER8_CTRL_IRQ_EN defined: a wrap sets irq; irq_clr in the same cycle as a second tc leaves irq=1; irq_clr alone then gives irq=0. Without the macro: irq stays 0 throughout.

Source files
------------

// File: rtl/pcler8_pkg.sv
// Shared definitions for the pcler8 reloadable counter controller.
// Holds the controller FSM state encoding and the default counter width.
package pcler8_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cnt8_next.sv
// Next-count logic for pcler8_ctrl: priority mux (load > clr > count > hold),
// increment, all-ones detect and reload select on wrap.
// Ports:
//   load, clr, cnt_en  - per-cycle controls
//   frozen             - controller is in DONE, counting suppressed
//   count              - current registered count
//   load_data, reload  - parallel load value and current reload value
//   next_count_c       - value the count register takes on the next edge
//   wrap_c             - a wrap happens on the next edge
module cnt8_next
  import pcler8_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             load,
  input  logic             clr,
  input  logic             cnt_en,
  input  logic             frozen,
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] load_data,
  input  logic [WIDTH-1:0] reload,
  output logic [WIDTH-1:0] next_count_c,
  output logic             wrap_c
);

  logic all_ones_c;

  assign all_ones_c = &count;

  // Priority mux; an all-ones count takes the reload value instead of 0.
  always_comb begin
    next_count_c = count;
    wrap_c       = 1'b0;
    if (load) begin
      next_count_c = load_data;
    end else if (clr) begin
      next_count_c = '0;
    end else if (cnt_en && !frozen) begin
      if (all_ones_c) begin
        next_count_c = reload;
        wrap_c       = 1'b1;
      end else begin
        next_count_c = count + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/pcler8_ctrl.sv
// Reloadable up-counter controller with IDLE/RUN/DONE FSM.
// Ports:
//   clk, rst_n             - clock, async active-low reset
//   load, load_data        - parallel load (highest priority)
//   clr                    - synchronous clear
//   cnt_en                 - count-up enable
//   reload_we, reload_data - reload register write
//   count                  - registered count
//   tc                     - one-cycle pulse after each wrap
//   running                - FSM is in RUN
//   irq, irq_clr           - sticky wrap flag and its clear
// Build option: define PCLER8_CTRL_IRQ_EN to enable the irq flag; otherwise
// irq is tied low and irq_clr is ignored.
module pcler8_ctrl
  import pcler8_pkg::*;
#(
  parameter int unsigned      WIDTH      = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RELOAD_RST = '0,
  parameter bit               ONE_SHOT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clr,
  input  logic             cnt_en,
  input  logic [WIDTH-1:0] load_data,
  input  logic             reload_we,
  input  logic [WIDTH-1:0] reload_data,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             running,
  output logic             irq,
  input  logic             irq_clr
);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] reload;
  logic [WIDTH-1:0] next_count_c;
  logic             wrap_c;

  cnt8_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .load         (load),
    .clr          (clr),
    .cnt_en       (cnt_en),
    .frozen       (state == DONE),
    .count        (count),
    .load_data    (load_data),
    .reload       (reload),
    .next_count_c (next_count_c),
    .wrap_c       (wrap_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state; DONE is only entered on a wrap in one-shot builds.
  always_comb begin
    state_next = state;
    if (load || clr) begin
      state_next = IDLE;
    end else if (state == DONE) begin
      state_next = DONE;
    end else if (cnt_en) begin
      state_next = (wrap_c && ONE_SHOT) ? DONE : RUN;
    end else begin
      state_next = IDLE;
    end
  end

  // Datapath and status registers; reload write lands after a same-cycle wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      reload  <= RELOAD_RST;
      tc      <= 1'b0;
      running <= 1'b0;
    end else begin
      count   <= next_count_c;
      tc      <= wrap_c;
      running <= (state_next == RUN);
      if (reload_we) begin
        reload <= reload_data;
      end
    end
  end

`ifdef PCLER8_CTRL_IRQ_EN
  // Sticky flag: a set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq <= 1'b0;
    end else begin
      irq <= tc | (irq & ~irq_clr);
    end
  end
`else
  logic unused_irq_clr;
  assign unused_irq_clr = irq_clr;
  assign irq            = 1'b0;
`endif

endmodule

// File: tb/tb_pcler8_ctrl.sv
// Self-checking bench for pcler8_ctrl: vector table, hand-written corner
// sequences and randomized traffic against a behavioural model.
module tb_pcler8_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load, clr, cnt_en, reload_we, irq_clr;
  logic [7:0] load_data, reload_data;
  logic [7:0] count0, count1;
  logic       tc0, tc1, run0, run1, irq0, irq1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pcler8_ctrl #(.WIDTH(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .load(load), .clr(clr), .cnt_en(cnt_en),
    .load_data(load_data), .reload_we(reload_we), .reload_data(reload_data),
    .count(count0), .tc(tc0), .running(run0), .irq(irq0), .irq_clr(irq_clr)
  );

  pcler8_ctrl #(.WIDTH(8), .RELOAD_RST(8'h07), .ONE_SHOT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .load(load), .clr(clr), .cnt_en(cnt_en),
    .load_data(load_data), .reload_we(reload_we), .reload_data(reload_data),
    .count(count1), .tc(tc1), .running(run1), .irq(irq1), .irq_clr(irq_clr)
  );

  typedef struct packed {
    logic       ld;
    logic       cl;
    logic       en;
    logic [7:0] ldata;
    logic       rwe;
    logic [7:0] rdata;
    logic       iclr;
  } in_t;

  typedef struct packed {
    in_t        i;
    logic [7:0] cnt;
    logic       tc;
    logic       run;
  } vec_t;

  // mode: 0 idle, 1 counting, 2 stopped after a one-shot wrap
  typedef struct {
    int cnt;
    int rel;
    bit tc;
    int mode;
    bit irq;
  } mdl_t;

  mdl_t m0, m1;

  function automatic mdl_t mstep(mdl_t m, in_t i, bit one_shot);
    mdl_t n;
    n    = m;
    n.tc = 1'b0;
`ifdef PCLER8_CTRL_IRQ_EN
    n.irq = m.tc || (m.irq && !i.iclr);
`else
    n.irq = 1'b0;
`endif
    if (i.ld) begin
      n.cnt  = int'(i.ldata);
      n.mode = 0;
    end else if (i.cl) begin
      n.cnt  = 0;
      n.mode = 0;
    end else if (m.mode == 2) begin
      n.mode = 2;
    end else if (i.en) begin
      if (m.cnt == 255) begin
        n.cnt  = m.rel;
        n.tc   = 1'b1;
        n.mode = one_shot ? 2 : 1;
      end else begin
        n.cnt  = m.cnt + 1;
        n.mode = 1;
      end
    end else begin
      n.mode = 0;
    end
    if (i.rwe) n.rel = int'(i.rdata);
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_models();
    chk("count0", 32'(count0), 32'(m0.cnt));
    chk("tc0", 32'(tc0), 32'(m0.tc));
    chk("running0", 32'(run0), 32'(m0.mode == 1));
    chk("irq0", 32'(irq0), 32'(m0.irq));
    chk("count1", 32'(count1), 32'(m1.cnt));
    chk("tc1", 32'(tc1), 32'(m1.tc));
    chk("running1", 32'(run1), 32'(m1.mode == 1));
    chk("irq1", 32'(irq1), 32'(m1.irq));
  endtask

  task automatic drive(input in_t i);
    load        = i.ld;
    clr         = i.cl;
    cnt_en      = i.en;
    load_data   = i.ldata;
    reload_we   = i.rwe;
    reload_data = i.rdata;
    irq_clr     = i.iclr;
  endtask

  // One clock cycle with the given inputs, then compare against the model.
  task automatic tick(input in_t i);
    drive(i);
    @(posedge clk);
    #1;
    m0 = mstep(m0, i, 1'b0);
    m1 = mstep(m1, i, 1'b1);
    chk_models();
  endtask

  function automatic in_t mk(bit ld, bit cl, bit en, logic [7:0] ldata,
                             bit rwe, logic [7:0] rdata, bit iclr);
    in_t i;
    i.ld = ld; i.cl = cl; i.en = en; i.ldata = ldata;
    i.rwe = rwe; i.rdata = rdata; i.iclr = iclr;
    return i;
  endfunction

  task automatic model_reset();
    m0 = '{cnt: 0, rel: 0, tc: 1'b0, mode: 0, irq: 1'b0};
    m1 = '{cnt: 0, rel: 7, tc: 1'b0, mode: 0, irq: 1'b0};
  endtask

  task automatic do_reset();
    drive(mk(0, 0, 0, 8'h00, 0, 8'h00, 0));
    rst_n = 1'b0;
    @(negedge clk);
    model_reset();
    chk_models();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tbl[15];
  in_t  idle_i;
  in_t  r;

  initial begin
    idle_i = mk(0, 0, 0, 8'h00, 0, 8'h00, 0);
    rst_n  = 1'b1;
    drive(idle_i);
    #2;

    // Directed vector table for the default (free-running) instance.
    tbl[0]  = '{mk(0, 0, 0, 8'h00, 1, 8'h10, 0), 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{mk(1, 0, 0, 8'hFD, 0, 8'h00, 0), 8'hFD, 1'b0, 1'b0};
    tbl[2]  = '{mk(0, 0, 1, 8'h00, 0, 8'h00, 0), 8'hFE, 1'b0, 1'b1};
    tbl[3]  = '{mk(0, 0, 1, 8'h00, 0, 8'h00, 0), 8'hFF, 1'b0, 1'b1};
    tbl[4]  = '{mk(0, 0, 1, 8'h00, 0, 8'h00, 0), 8'h10, 1'b1, 1'b1};
    tbl[5]  = '{mk(0, 0, 1, 8'h00, 0, 8'h00, 0), 8'h11, 1'b0, 1'b1};
    tbl[6]  = '{mk(0, 0, 0, 8'h00, 0, 8'h00, 0), 8'h11, 1'b0, 1'b0};
    tbl[7]  = '{mk(1, 1, 1, 8'h5A, 0, 8'h00, 0), 8'h5A, 1'b0, 1'b0};
    tbl[8]  = '{mk(0, 1, 0, 8'h00, 0, 8'h00, 0), 8'h00, 1'b0, 1'b0};
    tbl[9]  = '{mk(1, 0, 0, 8'hFF, 0, 8'h00, 0), 8'hFF, 1'b0, 1'b0};
    tbl[10] = '{mk(0, 0, 1, 8'h00, 1, 8'h33, 0), 8'h10, 1'b1, 1'b1};
    tbl[11] = '{mk(1, 0, 0, 8'hFF, 0, 8'h00, 0), 8'hFF, 1'b0, 1'b0};
    tbl[12] = '{mk(0, 0, 1, 8'h00, 0, 8'h00, 0), 8'h33, 1'b1, 1'b1};
    tbl[13] = '{mk(0, 0, 1, 8'h00, 0, 8'h00, 0), 8'h34, 1'b0, 1'b1};
    tbl[14] = '{mk(0, 0, 0, 8'h00, 0, 8'h00, 0), 8'h34, 1'b0, 1'b0};

    do_reset();
    for (int k = 0; k < 15; k++) begin
      tick(tbl[k].i);
      chk($sformatf("tbl%0d_count", k), 32'(count0), 32'(tbl[k].cnt));
      chk($sformatf("tbl%0d_tc", k), 32'(tc0), 32'(tbl[k].tc));
      chk($sformatf("tbl%0d_running", k), 32'(run0), 32'(tbl[k].run));
    end

    // One-shot: wrap freezes the count until clr.
    do_reset();
    tick(mk(0, 0, 0, 8'h00, 1, 8'h10, 0));
    tick(mk(1, 0, 0, 8'hFF, 0, 8'h00, 0));
    tick(mk(0, 0, 1, 8'h00, 0, 8'h00, 0));
    chk("oneshot_wrap_count", 32'(count1), 32'h10);
    chk("oneshot_wrap_tc", 32'(tc1), 32'h1);
    chk("oneshot_wrap_running", 32'(run1), 32'h0);
    for (int k = 0; k < 5; k++) begin
      tick(mk(0, 0, 1, 8'h00, 0, 8'h00, 0));
      chk("oneshot_frozen_count", 32'(count1), 32'h10);
      chk("oneshot_frozen_tc", 32'(tc1), 32'h0);
      chk("oneshot_frozen_running", 32'(run1), 32'h0);
    end
    tick(mk(0, 1, 1, 8'h00, 0, 8'h00, 0));
    chk("oneshot_clr_count", 32'(count1), 32'h00);
    chk("oneshot_clr_running", 32'(run1), 32'h0);
    tick(mk(0, 0, 1, 8'h00, 0, 8'h00, 0));
    chk("oneshot_restart_count", 32'(count1), 32'h01);
    chk("oneshot_restart_running", 32'(run1), 32'h1);

    // Reset parameter of the reload register: wrap from FF reloads RELOAD_RST.
    do_reset();
    tick(mk(1, 0, 0, 8'hFF, 0, 8'h00, 0));
    tick(mk(0, 0, 1, 8'h00, 0, 8'h00, 0));
    chk("reload_rst0", 32'(count0), 32'h00);
    chk("reload_rst1", 32'(count1), 32'h07);

    // Asynchronous reset mid-count.
    do_reset();
    tick(mk(1, 0, 0, 8'h40, 0, 8'h00, 0));
    tick(mk(0, 0, 1, 8'h00, 0, 8'h00, 0));
    tick(mk(0, 0, 1, 8'h00, 0, 8'h00, 0));
    chk("pre_reset_count", 32'(count0), 32'h42);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_count", 32'(count0), 32'h00);
    chk("async_reset_tc", 32'(tc0), 32'h0);
    chk("async_reset_irq", 32'(irq0), 32'h0);
    chk("async_reset_running", 32'(run0), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick(idle_i);
    chk("post_reset_hold", 32'(count0), 32'h00);
    tick(mk(0, 0, 1, 8'h00, 0, 8'h00, 0));
    chk("post_reset_resume", 32'(count0), 32'h01);

    // Sticky irq flag.
    do_reset();
    tick(mk(1, 0, 0, 8'hFF, 0, 8'h00, 0));
    tick(mk(0, 0, 1, 8'h00, 0, 8'h00, 0));
    tick(mk(1, 0, 0, 8'hFF, 0, 8'h00, 0));
`ifdef PCLER8_CTRL_IRQ_EN
    chk("irq_set", 32'(irq0), 32'h1);
`else
    chk("irq_tied", 32'(irq0), 32'h0);
`endif
    tick(mk(0, 0, 1, 8'h00, 0, 8'h00, 0));
    chk("second_tc", 32'(tc0), 32'h1);
    tick(mk(0, 0, 0, 8'h00, 0, 8'h00, 1));
`ifdef PCLER8_CTRL_IRQ_EN
    chk("irq_set_wins", 32'(irq0), 32'h1);
`else
    chk("irq_tied", 32'(irq0), 32'h0);
`endif
    tick(mk(0, 0, 0, 8'h00, 0, 8'h00, 1));
    chk("irq_cleared", 32'(irq0), 32'h0);

    // Randomized traffic, biased towards wraps.
    do_reset();
    for (int k = 0; k < 600; k++) begin
      r.ld    = ($urandom_range(0, 15) == 0);
      r.cl    = ($urandom_range(0, 24) == 0);
      r.en    = ($urandom_range(0, 7) != 0);
      r.ldata = ($urandom_range(0, 1) == 1) ? 8'(8'hF8 + $urandom_range(0, 7))
                                            : 8'($urandom);
      r.rwe   = ($urandom_range(0, 9) == 0);
      r.rdata = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
      r.iclr  = ($urandom_range(0, 5) == 0);
      tick(r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
